// File: rtl/uart_csr_responder.sv
// ---------------------------------------------------------------------------
// uart_csr_responder
//
// Memory-mapped CSR block for the UART. It decodes CSR accesses from the MIPS
// data bus and buffers bytes in a TX FIFO and an RX FIFO. It also exposes the
// STATUS, CTRL and BAUD registers and drives a level interrupt.
//
// Register map (index):
//   0 TXDATA  W pushes wr_data[7:0]; reads 0
//   1 RXDATA  R pops the RX FIFO head (0, no pop, when empty)
//   2 STATUS  R {rx_count, tx_count, tx_ovf, frame_err, rx_ovr,
//               rx_full, rx_empty, tx_empty, tx_full}
//   3 CTRL    RW {loopback, clr_sticky(w1, reads 0), irq_txe_en,
//               irq_rx_en, rx_en, tx_en}
//   4 BAUD    RW [15:0]
//   5-7       read 0, writes ignored
//
// Optional feature macro: UART_CSR_LOOPBACK_EN. It adds CTRL bit5, which
// routes the TX FIFO into the RX FIFO internally.
//
// Ports:
//   clk, rst_n                      core clock, async active-low reset
//   csr_wr_addr/csr_wr_data/csr_wen write access (strobe may be held)
//   csr_rd_addr/csr_ren             read access (strobe may be held)
//   csr_rd_data                     registered read data
//   tx_data/tx_valid/tx_ready       byte stream to the tx core
//   rx_data/rx_valid/rx_frame_err   byte pulses from the rx core
//   baud_div                        divisor to the tx/rx cores
//   irq                             registered level interrupt
// ---------------------------------------------------------------------------
module uart_csr_responder #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            csr_wr_addr,
    input  logic [DATA_WIDTH-1:0] csr_wr_data,
    input  logic                  csr_wen,
    input  logic [2:0]            csr_rd_addr,
    input  logic                  csr_ren,
    output logic [DATA_WIDTH-1:0] csr_rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_frame_err,
    output logic [15:0]           baud_div,
    output logic                  irq
);
    localparam int unsigned   AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [2:0] A_TXDATA = 3'd0;
    localparam logic [2:0] A_RXDATA = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_BAUD   = 3'd4;

    logic [7:0]            tx_mem_q [FIFO_DEPTH];
    logic [7:0]            rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]         tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]         tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
    logic                  tx_en_q, rx_en_q, irq_rx_en_q, irq_txe_en_q;
    logic                  irq_rx_en_d, irq_txe_en_d;
    logic [15:0]           baud_q;
    logic                  rx_ovr_q, frame_err_q, tx_ovf_q;
    logic                  wen_prev_q, ren_prev_q;
    logic [2:0]            wr_addr_prev_q, rd_addr_prev_q;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  irq_q, irq_d;

    logic                  wr_first, rd_first, ctrl_wr, clr_sticky;
    logic                  tx_empty, tx_full, rx_empty, rx_full;
    logic                  tx_pop, tx_push_req, tx_push;
    logic                  rx_pop, core_rx, rx_push_req, rx_push;
    logic                  lb_act, lb_move;
    logic [7:0]            tx_head, rx_push_byte;
    logic [DATA_WIDTH-1:0] status, ctrl_rd;
    logic                  unused_wdata;

    assign unused_wdata = ^csr_wr_data[DATA_WIDTH-1:16];

    // An access is "new" unless the same strobe hit the same index last cycle,
    // so a held strobe produces exactly one push or pop.
    assign wr_first   = csr_wen & ~(wen_prev_q & (wr_addr_prev_q == csr_wr_addr));
    assign rd_first   = csr_ren & ~(ren_prev_q & (rd_addr_prev_q == csr_rd_addr));
    assign ctrl_wr    = wr_first & (csr_wr_addr == A_CTRL);
    assign clr_sticky = ctrl_wr & csr_wr_data[4];

`ifdef UART_CSR_LOOPBACK_EN
    logic lb_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_q <= 1'b0;
        end else if (ctrl_wr) begin
            lb_q <= csr_wr_data[5];
        end
    end
    assign lb_act = lb_q;
`else
    assign lb_act = 1'b0;
`endif

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

    assign tx_head  = tx_mem_q[tx_rp_q];
    assign tx_data  = tx_empty ? 8'h00 : tx_head;
    assign tx_valid = tx_en_q & ~tx_empty & ~lb_act;

    // Loopback only moves a byte when RX has room, so it never overruns.
    assign lb_move     = lb_act & ~tx_empty & ~rx_full;
    assign tx_pop      = lb_act ? lb_move : (tx_valid & tx_ready);
    assign tx_push_req = wr_first & (csr_wr_addr == A_TXDATA);
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    assign rx_pop       = rd_first & (csr_rd_addr == A_RXDATA) & ~rx_empty;
    assign core_rx      = rx_valid & rx_en_q & ~lb_act;
    assign rx_push_req  = lb_move | core_rx;
    assign rx_push      = rx_push_req & (~rx_full | rx_pop);
    assign rx_push_byte = lb_act ? tx_head : rx_data;

    assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

    // The interrupt is computed from next-state values so it follows its
    // cause by exactly one clock.
    assign irq_rx_en_d  = ctrl_wr ? csr_wr_data[2] : irq_rx_en_q;
    assign irq_txe_en_d = ctrl_wr ? csr_wr_data[3] : irq_txe_en_q;
    assign irq_d        = (irq_rx_en_d & (rx_cnt_d != '0)) | (irq_txe_en_d & (tx_cnt_d == '0));

    always_comb begin
        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_empty;
        status[3]     = rx_full;
        status[4]     = rx_ovr_q;
        status[5]     = frame_err_q;
        status[6]     = tx_ovf_q;
        status[15:8]  = 8'(tx_cnt_q);
        status[23:16] = 8'(rx_cnt_q);

        ctrl_rd    = '0;
        ctrl_rd[0] = tx_en_q;
        ctrl_rd[1] = rx_en_q;
        ctrl_rd[2] = irq_rx_en_q;
        ctrl_rd[3] = irq_txe_en_q;
        ctrl_rd[5] = lb_act;

        rd_data_d = rd_data_q;
        if (rd_first) begin
            case (csr_rd_addr)
                A_RXDATA: rd_data_d = rx_empty ? '0 : DATA_WIDTH'(rx_mem_q[rx_rp_q]);
                A_STATUS: rd_data_d = status;
                A_CTRL:   rd_data_d = ctrl_rd;
                A_BAUD:   rd_data_d = DATA_WIDTH'(baud_q);
                default:  rd_data_d = '0;
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= csr_wr_data[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_push_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q        <= '0;
            tx_rp_q        <= '0;
            tx_cnt_q       <= '0;
            rx_wp_q        <= '0;
            rx_rp_q        <= '0;
            rx_cnt_q       <= '0;
            tx_en_q        <= 1'b1;
            rx_en_q        <= 1'b1;
            irq_rx_en_q    <= 1'b0;
            irq_txe_en_q   <= 1'b0;
            baud_q         <= BAUD_DIV_RST;
            rx_ovr_q       <= 1'b0;
            frame_err_q    <= 1'b0;
            tx_ovf_q       <= 1'b0;
            wen_prev_q     <= 1'b0;
            ren_prev_q     <= 1'b0;
            wr_addr_prev_q <= '0;
            rd_addr_prev_q <= '0;
            rd_data_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            wen_prev_q     <= csr_wen;
            ren_prev_q     <= csr_ren;
            wr_addr_prev_q <= csr_wr_addr;
            rd_addr_prev_q <= csr_rd_addr;

            if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;

            if (ctrl_wr) begin
                tx_en_q <= csr_wr_data[0];
                rx_en_q <= csr_wr_data[1];
            end
            irq_rx_en_q  <= irq_rx_en_d;
            irq_txe_en_q <= irq_txe_en_d;
            if (wr_first && (csr_wr_addr == A_BAUD)) baud_q <= csr_wr_data[15:0];

            // A new error in the same cycle as a clear wins over the clear.
            if (clr_sticky) begin
                rx_ovr_q    <= 1'b0;
                frame_err_q <= 1'b0;
                tx_ovf_q    <= 1'b0;
            end
            if (tx_push_req && !tx_push) tx_ovf_q    <= 1'b1;
            if (rx_push_req && !rx_push) rx_ovr_q    <= 1'b1;
            if (core_rx && rx_frame_err) frame_err_q <= 1'b1;

            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign csr_rd_data = rd_data_q;
    assign baud_div    = baud_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_uart_csr_responder.sv
// ---------------------------------------------------------------------------
// Testbench for uart_csr_responder (default build, loopback macro undefined).
// A queue-based reference model tracks both FIFOs, the sticky flags, CTRL and
// BAUD. Every cycle the DUT outputs are compared against that model.
// ---------------------------------------------------------------------------
module tb_uart_csr_responder;
    localparam int D = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        csr_wen;
    logic [2:0]  csr_rd_addr;
    logic        csr_ren;
    logic [31:0] csr_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic [15:0] baud_div;
    logic        irq;

    uart_csr_responder #(
        .FIFO_DEPTH  (D),
        .DATA_WIDTH  (32),
        .BAUD_DIV_RST(16'd434)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_wr_addr (csr_wr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_wen     (csr_wen),
        .csr_rd_addr (csr_rd_addr),
        .csr_ren     (csr_ren),
        .csr_rd_data (csr_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .baud_div    (baud_div),
        .irq         (irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    bit          ovf_m, ferr_m, ovr_m, irq_m;
    logic [3:0]  ctrl_m;
    logic [15:0] baud_m;
    logic [31:0] rd_m;
    bit          pwen, pren;
    logic [2:0]  pwa, pra;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s        = '0;
        s[0]     = (tx_q.size() == D);
        s[1]     = (tx_q.size() == 0);
        s[2]     = (rx_q.size() == 0);
        s[3]     = (rx_q.size() == D);
        s[4]     = ovr_m;
        s[5]     = ferr_m;
        s[6]     = ovf_m;
        s[15:8]  = 8'(tx_q.size());
        s[23:16] = 8'(rx_q.size());
        return s;
    endfunction

    function automatic logic [31:0] read_m(input logic [2:0] a);
        case (a)
            3'd1:    return (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'h0;
            3'd2:    return status_m();
            3'd3:    return {28'h0, ctrl_m};
            3'd4:    return {16'h0, baud_m};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        ovf_m  = 0;
        ferr_m = 0;
        ovr_m  = 0;
        irq_m  = 0;
        ctrl_m = 4'h3;
        baud_m = 16'd434;
        rd_m   = 32'h0;
        pwen   = 0;
        pren   = 0;
        pwa    = '0;
        pra    = '0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then
    // clock the DUT and compare all outputs just after the edge.
    task automatic cycle();
        bit wf, rf, txp, rxp;
        wf  = csr_wen && !(pwen && pwa == csr_wr_addr);
        rf  = csr_ren && !(pren && pra == csr_rd_addr);
        if (rf) rd_m = read_m(csr_rd_addr);
        txp = ctrl_m[0] && (tx_q.size() > 0) && tx_ready;
        rxp = rf && (csr_rd_addr == 3'd1) && (rx_q.size() > 0);
        if (txp) void'(tx_q.pop_front());
        if (rxp) void'(rx_q.pop_front());
        if (wf && csr_wr_addr == 3'd3 && csr_wr_data[4]) begin
            ovf_m  = 0;
            ferr_m = 0;
            ovr_m  = 0;
        end
        if (rx_valid && ctrl_m[1]) begin
            if (rx_frame_err) ferr_m = 1;
            if (rx_q.size() < D) rx_q.push_back(rx_data);
            else ovr_m = 1;
        end
        if (wf && csr_wr_addr == 3'd0) begin
            if (tx_q.size() < D) tx_q.push_back(csr_wr_data[7:0]);
            else ovf_m = 1;
        end
        if (wf && csr_wr_addr == 3'd3) ctrl_m = csr_wr_data[3:0];
        if (wf && csr_wr_addr == 3'd4) baud_m = csr_wr_data[15:0];
        irq_m = (ctrl_m[2] && rx_q.size() > 0) || (ctrl_m[3] && tx_q.size() == 0);
        pwen = csr_wen;
        pren = csr_ren;
        pwa  = csr_wr_addr;
        pra  = csr_rd_addr;

        @(posedge clk);
        #1;
        check_val("tx_valid", 32'(tx_valid), 32'(ctrl_m[0] && tx_q.size() > 0));
        check_val("tx_data", 32'(tx_data), (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'h0);
        check_val("irq", 32'(irq), 32'(irq_m));
        check_val("baud_div", 32'(baud_div), 32'(baud_m));
        check_val("rd_data", csr_rd_data, rd_m);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input int hold);
        csr_wr_addr = a;
        csr_wr_data = d;
        csr_wen     = 1'b1;
        repeat (hold) cycle();
        csr_wen = 1'b0;
        cycle();
    endtask

    task automatic rd(input logic [2:0] a, input int hold);
        csr_rd_addr = a;
        csr_ren     = 1'b1;
        repeat (hold) cycle();
        csr_ren = 1'b0;
        cycle();
    endtask

    task automatic rx_pulse(input logic [7:0] b, input logic fe);
        rx_data      = b;
        rx_frame_err = fe;
        rx_valid     = 1'b1;
        cycle();
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        cycle();
    endtask

    initial begin
        rst_n        = 1'b0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;
        csr_wen      = 1'b0;
        csr_rd_addr  = '0;
        csr_ren      = 1'b0;
        tx_ready     = 1'b0;
        rx_data      = '0;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        #12;
        check_val("rst_tx_valid", 32'(tx_valid), 32'h0);
        check_val("rst_irq", 32'(irq), 32'h0);
        check_val("rst_tx_data", 32'(tx_data), 32'h0);
        check_val("rst_rd_data", csr_rd_data, 32'h0);
        check_val("rst_baud", 32'(baud_div), 32'd434);
        model_reset();
        rst_n = 1'b1;

        // Reset register values
        rd(3'd3, 1); check_val("ctrl_rst", csr_rd_data, 32'h3);
        rd(3'd4, 1); check_val("baud_rst", csr_rd_data, 32'd434);
        rd(3'd2, 1); check_val("status_rst", csr_rd_data, 32'h6);

        // Held write pushes once; one handshake drains it
        wr(3'd0, 32'hA5, 3);
        rd(3'd2, 1); check_val("tx_count_1", 32'(csr_rd_data[15:8]), 32'd1);
        check_val("tx_head_a5", 32'(tx_data), 32'hA5);
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        rd(3'd2, 1); check_val("tx_empty", 32'(csr_rd_data[1]), 32'd1);

        // TX overflow, ordered drain, sticky clear
        for (int i = 0; i < 9; i++) wr(3'd0, 32'(i), 1);
        rd(3'd2, 1);
        check_val("tx_count_8", 32'(csr_rd_data[15:8]), 32'd8);
        check_val("tx_full", 32'(csr_rd_data[0]), 32'd1);
        check_val("tx_ovf", 32'(csr_rd_data[6]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_val("drain_byte", 32'(tx_data), 32'(i));
            tx_ready = 1'b1;
            cycle();
        end
        tx_ready = 1'b0;
        wr(3'd3, 32'h13, 1);
        rd(3'd2, 1); check_val("tx_ovf_clr", 32'(csr_rd_data[6]), 32'd0);
        rd(3'd3, 1); check_val("ctrl_selfclr", csr_rd_data, 32'h3);

        // RX overrun and held reads popping once each
        for (int i = 0; i < 9; i++) rx_pulse(8'(8'h10 + i), 1'b0);
        rd(3'd2, 1); check_val("rx_overrun", 32'(csr_rd_data[4]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd(3'd1, 2);
            check_val("rx_byte", csr_rd_data, 32'(8'h10 + i));
        end
        rd(3'd1, 1); check_val("rx_empty_rd", csr_rd_data, 32'h0);
        rd(3'd2, 1); check_val("rx_count_0", 32'(csr_rd_data[23:16]), 32'd0);
        wr(3'd3, 32'h13, 1);

        // Push into a full RX FIFO in the same cycle as a pop
        for (int i = 0; i < 8; i++) rx_pulse(8'(8'h20 + i), 1'b0);
        csr_rd_addr = 3'd1;
        csr_ren     = 1'b1;
        rx_data     = 8'h55;
        rx_valid    = 1'b1;
        cycle();
        rx_valid = 1'b0;
        csr_ren  = 1'b0;
        cycle();
        check_val("rx_pop_same", csr_rd_data, 32'h20);
        rd(3'd2, 1);
        check_val("rx_count_8", 32'(csr_rd_data[23:16]), 32'd8);
        check_val("no_overrun", 32'(csr_rd_data[4]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'd1, 1);
            check_val("rx_after", csr_rd_data, (i < 7) ? 32'(8'h21 + i) : 32'h55);
        end

        // Frame error and RX interrupt
        wr(3'd3, 32'h7, 1);
        rx_data      = 8'h3C;
        rx_frame_err = 1'b1;
        rx_valid     = 1'b1;
        cycle();
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        check_val("irq_rx", 32'(irq), 32'd1);
        rd(3'd2, 1); check_val("frame_err", 32'(csr_rd_data[5]), 32'd1);
        csr_rd_addr = 3'd1;
        csr_ren     = 1'b1;
        cycle();
        check_val("irq_after_pop", 32'(irq), 32'd0);
        check_val("rx_3c", csr_rd_data, 32'h3C);
        csr_ren = 1'b0;
        cycle();

        // Asynchronous reset in the middle of a cycle
        wr(3'd3, 32'h13, 1);
        wr(3'd0, 32'h77, 1);
        check_val("pre_rst_valid", 32'(tx_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_tx_valid", 32'(tx_valid), 32'd0);
        check_val("async_tx_data", 32'(tx_data), 32'd0);
        check_val("async_rd_data", csr_rd_data, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        rd(3'd2, 1); check_val("status_rst2", csr_rd_data, 32'h6);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3, 0) != 0) begin
                csr_wen     = ($urandom_range(2, 0) == 0);
                csr_wr_addr = 3'($urandom_range(5, 0));
                csr_wr_data = $urandom;
                if (csr_wr_addr == 3'd3 && $urandom_range(3, 0) != 0) csr_wr_data[1:0] = 2'b11;
            end
            if ($urandom_range(3, 0) != 0) begin
                csr_ren     = ($urandom_range(1, 0) == 0);
                csr_rd_addr = ($urandom_range(1, 0) == 0) ? 3'd1 : 3'($urandom_range(7, 0));
            end
            tx_ready     = ($urandom_range(3, 0) == 0);
            rx_valid     = ($urandom_range(2, 0) == 0);
            rx_data      = 8'($urandom);
            rx_frame_err = ($urandom_range(7, 0) == 0);
            cycle();
        end
        csr_wen  = 1'b0;
        csr_ren  = 1'b0;
        rx_valid = 1'b0;
        rd(3'd2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
